peripheral_bus: RTL and testbench
=================================

Name: peripheral_bus

Overview:
Memory-mapped peripheral responder on the CPU data port. It sits beside the data memory in the MEM stage and serves loads and stores in the peripheral window. It provides a reloadable timer with interrupt, LEDs, switches, a 7-segment register and a free-running systick. Its `irq` output drives the CPU's interrupt input, and its read data is muxed with data-memory read data ahead of the MEM/WB register.

Parameters:
- BASE_ADDR, 32'h4000_0000, base of the 256-byte peripheral window (addr[31:8] == BASE_ADDR[31:8]).
- LED_WIDTH, 8, LED register width.
- SW_WIDTH, 8, switch input width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- MemRead  in  1  load strobe from EX/MEM boundary.
- MemWrite  in  1  store strobe.
- Address  in  32  byte address; bits [1:0] ignored.
- Write_data  in  32  store data.
- Read_data  out  32  registered load data.
- rd_hit  out  1  registered; Read_data is from this block this cycle (top-level mux select).
- switches  in  SW_WIDTH  board switches, already synchronised externally.
- leds  out  LED_WIDTH  LED register.
- digi  out  12  7-segment register (anode[11:8], segments[7:0]).
- irq  out  1  timer interrupt request, level.

Behaviour:
- Register map (offset, access, reset value):
  - 0x00 TH, RW, 0: timer reload value.
  - 0x04 TL, RW, 0: timer counter.
  - 0x08 TCON[2:0], RW, 0: [0] enable, [1] irq_en, [2] irq_status; bits [31:3] read 0.
  - 0x0C LED, RW, 0.
  - 0x10 SW, RO: reads zero-extended `switches`; writes ignored.
  - 0x14 DIGI[11:0], RW, 0.
  - 0x18 SYSTICK, RO, 0: free-running; writes ignored.
  - All other offsets in the window: read 0, writes ignored.
- Select: sel = (Address[31:8] == BASE_ADDR[31:8]). Outside the window the block ignores strobes entirely.
- Write: takes effect on the rising edge of the cycle where MemWrite && sel. Registers update one edge later.
- Read latency is 1 cycle:
  - Edge after MemRead && sel: Read_data <= addressed value as of before that edge; rd_hit <= 1.
  - Otherwise Read_data <= 0 and rd_hit <= 0.
- MemRead and MemWrite together at the same offset: the write is performed and the read returns the pre-write value.
- Timer runs each cycle while TCON[0] = 1:
  - TL != 32'hFFFF_FFFF: TL <= TL + 1.
  - TL == 32'hFFFF_FFFF (overflow): TL <= TH; if TCON[1], TCON[2] <= 1.
  - TCON[0] = 0: TL holds.
- Collision rules:
  - A CPU write to TL in the same cycle as an increment or overflow: the written value wins.
  - A CPU write to TCON in the same cycle as an overflow: TCON[2] <= Write_data[2] | (TCON[1]_old & overflow). The interrupt is never lost.
  - A CPU write to TH in the overflow cycle: TL reloads the old TH.
- irq = TCON[1] & TCON[2] (combinational from registers). Software clears it by writing TCON[2] = 0.
- SYSTICK increments every cycle and wraps 32'hFFFF_FFFF -> 0.
- Reset assertion at any time, mid-access included: all registers, Read_data, rd_hit and irq go to 0 immediately. Any pending read is discarded. The first valid access is possible on the first edge after deassertion.

Decomposition:
- Shared package holds:
  - register offsets (OFF_TH, OFF_TL, OFF_TCON, OFF_LED, OFF_SW, OFF_DIGI, OFF_SYSTICK);
  - TCON bit indices (TCON_EN, TCON_IE, TCON_IS);
  - default BASE_ADDR.
- One sub-module, timer_core: TH/TL/TCON storage, overflow/reload, write-collision rules and irq. It has a write port and read-outs. peripheral_bus keeps decode, LED/DIGI/SYSTICK and the read register.

Test Plan:
- Reset and idle: reset low mid-run -> Read_data, rd_hit, leds, digi and irq are 0 asynchronously. After release, read 0x4000_0018 twice, 5 cycles apart -> values differ by 5.
- Register RW: write LED=0xA5 and DIGI=0x3F7 -> leds=8'hA5 and digi=12'h3F7 one edge later. Reads return 0xA5 and 0x3F7 with rd_hit=1 one cycle after MemRead. Write SW -> ignored; read returns switches.
- Timer overflow/irq: TH=0xFFFF_FFFD, TL=0xFFFF_FFFD, TCON=3 -> TL reaches 0xFFFF_FFFF after 2 enabled cycles, reloads to 0xFFFF_FFFD on the next cycle, and irq rises in that same cycle.
- IRQ clear race: write TCON=3 (status clear) exactly in the overflow cycle -> TCON reads 7 and irq stays 1. Write TCON=3 one cycle later -> irq falls.
- Unmapped and out-of-window: read 0x4000_0020 -> Read_data=0 with rd_hit=1. Read 0x1000_0000 -> rd_hit=0. Write 0x0000_000C=0xFF -> leds unchanged.
- Read-during-write: MemRead and MemWrite to LED with 0x0F while LED=0xF0 -> Read_data=0xF0, then leds=0x0F.

Source files
------------

// File: rtl/peripheral_bus_pkg.sv
// Shared constants for the peripheral responder: register offsets inside the
// 256-byte window, TCON bit positions and the default window base.
package peripheral_bus_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  localparam logic [7:0] OFF_TH      = 8'h00;
  localparam logic [7:0] OFF_TL      = 8'h04;
  localparam logic [7:0] OFF_TCON    = 8'h08;
  localparam logic [7:0] OFF_LED     = 8'h0C;
  localparam logic [7:0] OFF_SW      = 8'h10;
  localparam logic [7:0] OFF_DIGI    = 8'h14;
  localparam logic [7:0] OFF_SYSTICK = 8'h18;

  localparam int TCON_EN = 0;  // timer enable
  localparam int TCON_IE = 1;  // interrupt enable
  localparam int TCON_IS = 2;  // interrupt status (sticky until software clears it)

endpackage

// File: rtl/peripheral_bus_timer_core.sv
// Reloadable 32-bit timer: TH/TL/TCON storage, overflow reload, CPU write
// collision handling and the level interrupt request.
module timer_core
  import peripheral_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,     // asynchronous, active-low
  input  logic        wr_th,
  input  logic        wr_tl,
  input  logic        wr_tcon,
  input  logic [31:0] wr_data,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);

  logic [31:0] th_reg, th_next;
  logic [31:0] tl_reg, tl_next;
  logic [2:0]  tcon_reg, tcon_next;
  logic        overflow;
  logic        status_set;

  // Next-state for the timer; a CPU write always beats the counter, but a
  // status bit raised by this cycle's overflow is OR-ed in so it cannot be lost.
  always_comb begin
    th_next    = th_reg;
    tl_next    = tl_reg;
    tcon_next  = tcon_reg;
    overflow   = tcon_reg[TCON_EN] && (tl_reg == 32'hFFFF_FFFF);
    status_set = tcon_reg[TCON_IE] && overflow;

    if (wr_th) th_next = wr_data;

    // Reload uses the TH value from before this edge, even if TH is being written.
    if (wr_tl)                   tl_next = wr_data;
    else if (overflow)           tl_next = th_reg;
    else if (tcon_reg[TCON_EN])  tl_next = tl_reg + 32'd1;

    if (wr_tcon) tcon_next = {wr_data[2] | status_set, wr_data[1:0]};
    else         tcon_next[TCON_IS] = tcon_reg[TCON_IS] | status_set;
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_reg   <= '0;
      tl_reg   <= '0;
      tcon_reg <= '0;
    end else begin
      th_reg   <= th_next;
      tl_reg   <= tl_next;
      tcon_reg <= tcon_next;
    end
  end

  assign th   = th_reg;
  assign tl   = tl_reg;
  assign tcon = tcon_reg;
  assign irq  = tcon_reg[TCON_IE] & tcon_reg[TCON_IS];

endmodule

// File: rtl/peripheral_bus.sv
// Memory-mapped peripheral responder: address decode, LED/DIGI/SYSTICK
// registers, the timer and a one-cycle registered read port.
module peripheral_bus
  import peripheral_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          LED_WIDTH = 8,
  parameter int          SW_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,      // asynchronous, active-low
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [31:0]          Address,
  input  logic [31:0]          Write_data,
  output logic [31:0]          Read_data,
  output logic                 rd_hit,
  input  logic [SW_WIDTH-1:0]  switches,
  output logic [LED_WIDTH-1:0] leds,
  output logic [11:0]          digi,
  output logic                 irq
);

  logic                 sel;
  logic [7:0]           offset;
  logic                 we;
  logic [LED_WIDTH-1:0] led_reg;
  logic [11:0]          digi_reg;
  logic [31:0]          systick_reg;
  logic [31:0]          rd_data_reg, rd_mux;
  logic                 rd_hit_reg;
  logic [31:0]          th, tl;
  logic [2:0]           tcon;

  // Word offset within the window; the byte-lane bits are masked off.
  assign offset = Address[7:0] & 8'hFC;
  assign sel    = (Address[31:8] == BASE_ADDR[31:8]);
  assign we     = MemWrite && sel;

  timer_core u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_th   (we && (offset == OFF_TH)),
    .wr_tl   (we && (offset == OFF_TL)),
    .wr_tcon (we && (offset == OFF_TCON)),
    .wr_data (Write_data),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irq     (irq)
  );

  // Read mux over the pre-edge register values; unmapped offsets read zero.
  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_TH:      rd_mux = th;
      OFF_TL:      rd_mux = tl;
      OFF_TCON:    rd_mux = 32'(tcon);
      OFF_LED:     rd_mux = 32'(led_reg);
      OFF_SW:      rd_mux = 32'(switches);
      OFF_DIGI:    rd_mux = 32'(digi_reg);
      OFF_SYSTICK: rd_mux = systick_reg;
      default:     rd_mux = '0;
    endcase
  end

  // LED/DIGI write registers and the free-running systick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_reg     <= '0;
      digi_reg    <= '0;
      systick_reg <= '0;
    end else begin
      systick_reg <= systick_reg + 32'd1;
      if (we && (offset == OFF_LED))  led_reg  <= Write_data[LED_WIDTH-1:0];
      if (we && (offset == OFF_DIGI)) digi_reg <= Write_data[11:0];
    end
  end

  // Registered read port; anything other than an in-window load returns zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_reg <= '0;
      rd_hit_reg  <= 1'b0;
    end else begin
      rd_hit_reg  <= MemRead && sel;
      rd_data_reg <= (MemRead && sel) ? rd_mux : 32'd0;
    end
  end

  assign Read_data = rd_data_reg;
  assign rd_hit    = rd_hit_reg;
  assign leds      = led_reg;
  assign digi      = digi_reg;

endmodule

// File: tb/tb_peripheral_bus.sv
// Self-checking bench for peripheral_bus: a vector table plus hand-written
// timer, reset and systick sequences; load results are checked through a
// scoreboard queue popped one edge after each load is issued.
module tb_peripheral_bus;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_DIGI = 32'h4000_0014;
  localparam logic [31:0] A_SYS  = 32'h4000_0018;
  localparam logic [7:0]  SW_VAL = 8'h5C;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        rd_hit;
  logic [7:0]  switches;
  logic [7:0]  leds;
  logic [11:0] digi;
  logic        irq;

  typedef struct {
    logic        hit;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic        hit;
    logic [31:0] data;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[16];
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] s1, s2;

  peripheral_bus dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .Write_data (Write_data),
    .Read_data  (Read_data),
    .rd_hit     (rd_hit),
    .switches   (switches),
    .leds       (leds),
    .digi       (digi),
    .irq        (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus transaction: drive on the falling edge, return just after the rising edge.
  task automatic bus(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic chk, input logic hit,
                     input logic [31:0] data);
    @(negedge clk);
    MemRead    = rd;
    MemWrite   = wr;
    Address    = addr;
    Write_data = wdata;
    if (chk) sb_q.push_back('{hit: hit, data: data});
    $display("txn t=%0t rd=%0b wr=%0b addr=%h wdata=%h", $time, rd, wr, addr, wdata);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Scoreboard monitor: compare each expected load result one edge after issue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("rd_hit", 32'(rd_hit), 32'(mon_e.hit));
        check("read_data", Read_data, mon_e.data);
      end
    end
  end

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    Address = '0; Write_data = '0; switches = SW_VAL;

    // Power-up reset.
    #2 reset = 1'b0;
    #1;
    check("reset_rd_hit", 32'(rd_hit), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Register read/write vectors.
    vecs[0]  = '{1'b0, 1'b1, A_LED,  32'h0000_00A5, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, A_DIGI, 32'h0000_03F7, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, A_LED,  32'h0,         1'b1, 1'b1, 32'h0000_00A5};
    vecs[3]  = '{1'b1, 1'b0, A_DIGI, 32'h0,         1'b1, 1'b1, 32'h0000_03F7};
    vecs[4]  = '{1'b0, 1'b1, A_SW,   32'h0000_0012, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, A_SW,   32'h0,         1'b1, 1'b1, 32'(SW_VAL)};
    vecs[6]  = '{1'b1, 1'b0, 32'h4000_0020, 32'h0,  1'b1, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h1000_0000, 32'h0,  1'b1, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_000C, 32'hFF, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, A_LED,  32'h0,         1'b1, 1'b1, 32'h0000_00A5};
    vecs[10] = '{1'b1, 1'b0, A_TH,   32'h0,         1'b1, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 1'b0, A_TCON, 32'h0,         1'b1, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 1'b1, A_TH,   32'h1234_5678, 1'b0, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b0, A_TH,   32'h0,         1'b1, 1'b1, 32'h1234_5678};
    vecs[14] = '{1'b0, 1'b1, 32'h4000_0024, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 1'b0, 32'h4000_0026, 32'h0,  1'b1, 1'b1, 32'h0};
    for (int i = 0; i < 16; i++)
      bus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
          vecs[i].chk, vecs[i].hit, vecs[i].data);
    check("leds_a5", 32'(leds), 32'h0000_00A5);
    check("digi_3f7", 32'(digi), 32'h0000_03F7);

    // Read-during-write to LED returns the old value.
    bus(1'b0, 1'b1, A_LED, 32'hF0, 1'b0, 1'b0, 32'h0);
    bus(1'b1, 1'b1, A_LED, 32'h0F, 1'b1, 1'b1, 32'hF0);
    check("leds_0f", 32'(leds), 32'h0000_000F);

    // Timer overflow, reload and interrupt.
    bus(1'b0, 1'b1, A_TH,   32'hFFFF_FFFD, 1'b0, 1'b0, 32'h0);
    bus(1'b0, 1'b1, A_TL,   32'hFFFF_FFFD, 1'b0, 1'b0, 32'h0);
    bus(1'b0, 1'b1, A_TCON, 32'h3, 1'b0, 1'b0, 32'h0);
    check("irq_start", 32'(irq), 32'd0);
    bus(1'b1, 1'b0, A_TL, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFD);
    bus(1'b1, 1'b0, A_TL, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    check("irq_pre_ovf", 32'(irq), 32'd0);
    bus(1'b1, 1'b0, A_TL, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    check("irq_ovf", 32'(irq), 32'd1);
    bus(1'b1, 1'b0, A_TL, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFD);
    bus(1'b1, 1'b0, A_TCON, 32'h0, 1'b1, 1'b1, 32'h7);
    bus(1'b0, 1'b1, A_TCON, 32'h0, 1'b0, 1'b0, 32'h0);
    check("irq_disabled", 32'(irq), 32'd0);

    // Status clear racing an overflow must not lose the interrupt.
    bus(1'b0, 1'b1, A_TL,   32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0);
    bus(1'b0, 1'b1, A_TCON, 32'h3, 1'b0, 1'b0, 32'h0);
    idle();
    bus(1'b0, 1'b1, A_TCON, 32'h3, 1'b0, 1'b0, 32'h0);
    check("irq_race_kept", 32'(irq), 32'd1);
    bus(1'b1, 1'b1, A_TCON, 32'h3, 1'b1, 1'b1, 32'h7);
    check("irq_cleared", 32'(irq), 32'd0);
    bus(1'b0, 1'b1, A_TCON, 32'h0, 1'b0, 1'b0, 32'h0);
    bus(1'b1, 1'b0, A_TCON, 32'h0, 1'b1, 1'b1, 32'h0);

    // CPU write to TL while counting wins over the increment.
    bus(1'b0, 1'b1, A_TCON, 32'h1, 1'b0, 1'b0, 32'h0);
    bus(1'b0, 1'b1, A_TL,   32'h100, 1'b0, 1'b0, 32'h0);
    bus(1'b1, 1'b0, A_TL, 32'h0, 1'b1, 1'b1, 32'h100);
    bus(1'b1, 1'b0, A_TL, 32'h0, 1'b1, 1'b1, 32'h101);
    bus(1'b0, 1'b1, A_TCON, 32'h0, 1'b0, 1'b0, 32'h0);
    bus(1'b1, 1'b0, A_TL, 32'h0, 1'b1, 1'b1, 32'h103);
    bus(1'b1, 1'b0, A_TL, 32'h0, 1'b1, 1'b1, 32'h103);

    // Asynchronous reset in the middle of a pending read.
    bus(1'b0, 1'b1, A_TCON, 32'h6, 1'b0, 1'b0, 32'h0);
    check("irq_forced", 32'(irq), 32'd1);
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; Address = A_LED;
    @(posedge clk);
    #2;
    check("pending_hit", 32'(rd_hit), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("mid_reset_read_data", Read_data, 32'h0);
    check("mid_reset_rd_hit", 32'(rd_hit), 32'd0);
    check("mid_reset_leds", 32'(leds), 32'd0);
    check("mid_reset_digi", 32'(digi), 32'd0);
    check("mid_reset_irq", 32'(irq), 32'd0);
    MemRead = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bus(1'b1, 1'b0, A_LED,  32'h0, 1'b1, 1'b1, 32'h0);
    bus(1'b1, 1'b0, A_TCON, 32'h0, 1'b1, 1'b1, 32'h0);

    // Systick: two reads five edges apart differ by five.
    bus(1'b1, 1'b0, A_SYS, 32'h0, 1'b0, 1'b0, 32'h0);
    s1 = Read_data;
    check("systick_hit", 32'(rd_hit), 32'd1);
    repeat (4) idle();
    bus(1'b1, 1'b0, A_SYS, 32'h0, 1'b0, 1'b0, 32'h0);
    s2 = Read_data;
    check("systick_delta", s2 - s1, 32'd5);

    idle();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
